// File: rtl/io_responder.sv
// CPU I/O responder: write-decoded LED/segment/interrupt/timer registers,
// synchronized switch and button inputs, and a combinational read mux.
module io_responder (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       io_strb,
    input  logic [7:0] switches,
    input  logic [3:0] buttons,
    output logic [7:0] in_port,
    output logic [7:0] leds,
    output logic [7:0] seg_data,
    output logic       interrupt
);

    logic [7:0] sw_meta_r, sw_sync_r;
    logic [3:0] btn_meta_r, btn_sync_r, btn_hist_r, btn_arm_r;
    logic [1:0] fill_r;
    logic [7:0] leds_r, seg_r, reload_r, count_r;
    logic [4:0] mask_r, pending_r;
    logic       tmr_en_r, int_r;

    logic       wr_leds_s, wr_seg_s, wr_mask_s, wr_ack_s, wr_reload_s, wr_ctrl_s;
    logic       sync_valid_s, tmr_fire_s;
    logic [3:0] btn_rise_s;
    logic [4:0] ack_clr_s, pending_next_s;
    logic [7:0] count_next_s, in_port_s;

    assign wr_leds_s   = io_strb && (port_id == 8'h40);
    assign wr_seg_s    = io_strb && (port_id == 8'h41);
    assign wr_mask_s   = io_strb && (port_id == 8'h42);
    assign wr_ack_s    = io_strb && (port_id == 8'h43);
    assign wr_reload_s = io_strb && (port_id == 8'h44);
    assign wr_ctrl_s   = io_strb && (port_id == 8'h45);

    // A button only counts as rising once it has been seen low after reset,
    // so a button held through reset release is not reported as an edge.
    assign sync_valid_s = (fill_r == 2'd2);
    assign btn_rise_s   = btn_sync_r & ~btn_hist_r & btn_arm_r;

    // Timer next state: a reload write wins over decrement and wrap.
    always_comb begin
        count_next_s = count_r;
        tmr_fire_s   = 1'b0;
        if (wr_reload_s) begin
            count_next_s = out_port;
        end else if (tmr_en_r) begin
            if (count_r == 8'h00) begin
                count_next_s = reload_r;
                tmr_fire_s   = 1'b1;
            end else begin
                count_next_s = count_r - 8'h01;
            end
        end else begin
            count_next_s = count_r;
        end
    end

    // Pending update: set has priority over a write-1-to-clear acknowledge.
    always_comb begin
        ack_clr_s      = 5'h00;
        if (wr_ack_s) begin
            ack_clr_s = out_port[4:0];
        end else begin
            ack_clr_s = 5'h00;
        end
        pending_next_s = (pending_r & ~ack_clr_s) | {tmr_fire_s, btn_rise_s};
    end

    // Read mux, purely combinational with no side effects.
    always_comb begin
        in_port_s = 8'h00;
        case (port_id)
            8'h20:   in_port_s = sw_sync_r;
            8'h21:   in_port_s = {4'b0000, btn_sync_r};
            8'h22:   in_port_s = {3'b000, pending_r};
            8'h23:   in_port_s = count_r;
            8'h24:   in_port_s = {3'b000, mask_r};
            default: in_port_s = 8'h00;
        endcase
    end

    // Input synchronizers, edge history and post-reset arming.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_meta_r  <= 8'h00;
            sw_sync_r  <= 8'h00;
            btn_meta_r <= 4'h0;
            btn_sync_r <= 4'h0;
            btn_hist_r <= 4'h0;
            btn_arm_r  <= 4'h0;
            fill_r     <= 2'd0;
        end else begin
            sw_meta_r  <= switches;
            sw_sync_r  <= sw_meta_r;
            btn_meta_r <= buttons;
            btn_sync_r <= btn_meta_r;
            btn_hist_r <= btn_sync_r;
            btn_arm_r  <= btn_arm_r | ({4{sync_valid_s}} & ~btn_sync_r);
            if (!sync_valid_s) begin
                fill_r <= fill_r + 2'd1;
            end
        end
    end

    // CPU-visible registers, timer, pending flags and interrupt.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            leds_r    <= 8'h00;
            seg_r     <= 8'h00;
            mask_r    <= 5'h00;
            pending_r <= 5'h00;
            reload_r  <= 8'h00;
            tmr_en_r  <= 1'b0;
            count_r   <= 8'h00;
            int_r     <= 1'b0;
        end else begin
            if (wr_leds_s)   leds_r   <= out_port;
            if (wr_seg_s)    seg_r    <= out_port;
            if (wr_mask_s)   mask_r   <= out_port[4:0];
            if (wr_reload_s) reload_r <= out_port;
            if (wr_ctrl_s)   tmr_en_r <= out_port[0];
            count_r   <= count_next_s;
            pending_r <= pending_next_s;
            int_r     <= |(pending_r & mask_r);
        end
    end

    assign in_port   = in_port_s;
    assign leds      = leds_r;
    assign seg_data  = seg_r;
    assign interrupt = int_r;

endmodule

// File: tb/tb_io_responder.sv
// Self-checking bench for io_responder: register-access vector table with a
// scoreboard queue, then directed button, timer, mask and reset sequences.
module tb_io_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] port_id = 8'h00;
    logic [7:0] out_port = 8'h00;
    logic       io_strb = 1'b0;
    logic [7:0] switches = 8'h00;
    logic [3:0] buttons = 4'h0;
    logic [7:0] in_port, leds, seg_data;
    logic       interrupt;

    int total = 0;
    int bad = 0;

    io_responder dut (
        .clk(clk), .rst(rst), .port_id(port_id), .out_port(out_port),
        .io_strb(io_strb), .switches(switches), .buttons(buttons),
        .in_port(in_port), .leds(leds), .seg_data(seg_data),
        .interrupt(interrupt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pid;
        logic [7:0] data;
        logic       strb;
        logic [7:0] exp_rd;
        logic [7:0] exp_leds;
        logic [7:0] exp_seg;
    } vec_t;

    typedef struct {
        logic [7:0] leds;
        logic [7:0] seg;
    } sb_t;

    vec_t vecs[14];
    sb_t  sbq[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        port_id  = a;
        out_port = d;
        io_strb  = 1'b1;
        @(negedge clk);
        io_strb  = 1'b0;
        port_id  = 8'h00;
        out_port = 8'h00;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] mcount;
        logic [4:0] mpend;
        logic       found;
        sb_t        e;

        switches = 8'h5A;
        vecs[0]  = '{8'h40, 8'hA5, 1'b1, 8'h00, 8'hA5, 8'h00};
        vecs[1]  = '{8'h50, 8'hFF, 1'b1, 8'h00, 8'hA5, 8'h00};
        vecs[2]  = '{8'h41, 8'h3C, 1'b1, 8'h00, 8'hA5, 8'h3C};
        vecs[3]  = '{8'h40, 8'h11, 1'b0, 8'h00, 8'hA5, 8'h3C};
        vecs[4]  = '{8'h24, 8'h00, 1'b0, 8'h00, 8'hA5, 8'h3C};
        vecs[5]  = '{8'h42, 8'hFF, 1'b1, 8'h00, 8'hA5, 8'h3C};
        vecs[6]  = '{8'h24, 8'h00, 1'b0, 8'h1F, 8'hA5, 8'h3C};
        vecs[7]  = '{8'h44, 8'h80, 1'b1, 8'h00, 8'hA5, 8'h3C};
        vecs[8]  = '{8'h23, 8'h00, 1'b0, 8'h80, 8'hA5, 8'h3C};
        vecs[9]  = '{8'h23, 8'h00, 1'b0, 8'h80, 8'hA5, 8'h3C};
        vecs[10] = '{8'h20, 8'h00, 1'b0, 8'h5A, 8'hA5, 8'h3C};
        vecs[11] = '{8'h21, 8'h00, 1'b0, 8'h00, 8'hA5, 8'h3C};
        vecs[12] = '{8'h42, 8'h00, 1'b1, 8'h00, 8'hA5, 8'h3C};
        vecs[13] = '{8'h22, 8'h00, 1'b0, 8'h00, 8'hA5, 8'h3C};

        // Reset state
        #2;
        chk("rst_leds", leds, 8'h00);
        chk("rst_seg", seg_data, 8'h00);
        chk("rst_int", {7'd0, interrupt}, 8'h00);
        reset_dut();

        // Vector table with scoreboard
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk($sformatf("vec%0d_leds", i - 1), leds, e.leds);
                chk($sformatf("vec%0d_seg", i - 1), seg_data, e.seg);
            end
            port_id  = vecs[i].pid;
            out_port = vecs[i].data;
            io_strb  = vecs[i].strb;
            #1;
            chk($sformatf("vec%0d_rd", i), in_port, vecs[i].exp_rd);
            sbq.push_back('{vecs[i].exp_leds, vecs[i].exp_seg});
        end
        @(negedge clk);
        io_strb = 1'b0;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("vec_last_leds", leds, e.leds);
            chk("vec_last_seg", seg_data, e.seg);
        end

        // Button interrupt
        reset_dut();
        wr(8'h42, 8'h01);
        buttons = 4'b0001;
        port_id = 8'h22;
        @(negedge clk); chk("btn_e1", in_port, 8'h00);
        @(negedge clk); chk("btn_e2", in_port, 8'h00);
        @(negedge clk); chk("btn_e3", in_port, 8'h01);
        chk("btn_e3_int", {7'd0, interrupt}, 8'h00);
        @(negedge clk); chk("btn_e4_int", {7'd0, interrupt}, 8'h01);
        wr(8'h43, 8'h01);
        port_id = 8'h22;
        #1;
        chk("ack_pend", in_port, 8'h00);
        chk("ack_int_hold", {7'd0, interrupt}, 8'h01);
        @(negedge clk); chk("ack_int_clr", {7'd0, interrupt}, 8'h00);
        buttons = 4'h0;

        // Timer period and count sequence
        reset_dut();
        wr(8'h44, 8'h03);
        port_id = 8'h23; #1;
        chk("tmr_load", in_port, 8'h03);
        wr(8'h45, 8'h01);
        port_id = 8'h23; #1;
        chk("tmr_hold_at_en", in_port, 8'h03);
        mcount = 8'h03;
        mpend  = 5'h00;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mcount == 8'h00) begin
                mcount = 8'h03;
                mpend[4] = 1'b1;
            end else begin
                mcount = mcount - 8'h01;
            end
            port_id = 8'h23; #1;
            chk($sformatf("tmr_cnt%0d", i), in_port, mcount);
            port_id = 8'h22; #1;
            chk($sformatf("tmr_pend%0d", i), in_port, {3'b000, mpend});
        end

        // Ack race: set and clear of PENDING[4] on the same edge
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            port_id = 8'h23; #1;
            if (in_port == 8'h00) found = 1'b1;
            else @(negedge clk);
        end
        chk("race_found", {7'd0, found}, 8'h01);
        port_id  = 8'h43;
        out_port = 8'h10;
        io_strb  = 1'b1;
        @(negedge clk);
        port_id  = 8'h22;
        io_strb  = 1'b0;
        #1;
        chk("race_set_wins", in_port, 8'h10);
        port_id  = 8'h43;
        io_strb  = 1'b1;
        @(negedge clk);
        port_id  = 8'h22;
        io_strb  = 1'b0;
        #1;
        chk("ack_no_set", in_port, 8'h00);

        // Reload of zero fires every cycle
        wr(8'h44, 8'h00);
        port_id = 8'h23; #1;
        chk("rl0_cnt", in_port, 8'h00);
        wr(8'h43, 8'h10);
        port_id = 8'h22; #1;
        chk("rl0_pend", in_port, 8'h10);

        // Masked pending
        reset_dut();
        buttons = 4'b0100;
        port_id = 8'h22;
        repeat (3) @(negedge clk);
        chk("mask_pend", in_port, 8'h04);
        @(negedge clk);
        chk("mask_int0", {7'd0, interrupt}, 8'h00);
        wr(8'h42, 8'h04);
        #1;
        chk("mask_int_same", {7'd0, interrupt}, 8'h00);
        @(negedge clk);
        chk("mask_int1", {7'd0, interrupt}, 8'h01);
        buttons = 4'h0;

        // Async reset mid-count with interrupt high
        reset_dut();
        wr(8'h40, 8'hAA);
        wr(8'h41, 8'h55);
        wr(8'h42, 8'h10);
        wr(8'h44, 8'h03);
        wr(8'h45, 8'h01);
        repeat (6) @(negedge clk);
        chk("pre_rst_int", {7'd0, interrupt}, 8'h01);
        buttons = 4'b0010;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_leds", leds, 8'h00);
        chk("arst_seg", seg_data, 8'h00);
        chk("arst_int", {7'd0, interrupt}, 8'h00);
        port_id = 8'h23; #1;
        chk("arst_cnt", in_port, 8'h00);
        port_id = 8'h20; #1;
        chk("arst_sw", in_port, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        port_id = 8'h22; #1;
        chk("held_btn_pend", in_port, 8'h00);
        chk("post_rst_int", {7'd0, interrupt}, 8'h00);
        port_id = 8'h23; #1;
        chk("post_rst_cnt", in_port, 8'h00);
        buttons = 4'h0;
        repeat (4) @(negedge clk);
        buttons = 4'b0010;
        repeat (3) @(negedge clk);
        port_id = 8'h22; #1;
        chk("rearm_pend", in_port, 8'h02);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/io_responder.md
IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 The block SHALL have one clock and one reset: rst is asynchronous and active-low, and all state SHALL use a single clock edge.
REQ-002 Ports SHALL be as follows (clock and reset first):
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- port_id  in  8  I/O address driven by the CPU.
- out_port  in  8  write data from the CPU.
- io_strb  in  1  write strobe, one cycle per CPU OUT.
- switches  in  8  asynchronous board switches.
- buttons  in  4  asynchronous board buttons.
- in_port  out  8  read data to the CPU.
- leds  out  8  LED register.
- seg_data  out  8  seven-segment data register.
- interrupt  out  1  level interrupt request to the CPU.

Function
REQ-003 Write decode: when io_strb=1 at a rising edge, out_port SHALL be stored into the register selected by port_id:
- 0x40 LEDS
- 0x41 SEG
- 0x42 INT_MASK[4:0]
- 0x43 INT_ACK, write-1-to-clear of PENDING[4:0]
- 0x44 TMR_RELOAD
- 0x45 TMR_CTRL[0] (enable)
- Writes to any other address SHALL be ignored.
REQ-004 leds SHALL equal LEDS, and seg_data SHALL equal SEG, with no extra latency, so a write is visible the cycle after the strobe edge.
REQ-005 Reads SHALL be combinational from port_id and have no side effects; in_port SHALL be selected as follows:
- 0x20: synchronized switches
- 0x21: {4'b0, synchronized buttons}
- 0x22: {3'b0, PENDING}
- 0x23: TMR_COUNT
- 0x24: {3'b0, INT_MASK}
- any other address: 0x00
REQ-006 switches and buttons SHALL each pass through a 2-flop synchronizer before any use.
REQ-007 Button edge detect: a rising edge on synchronized button k SHALL set PENDING[k]; a button held high for one input clock SHALL set PENDING[k] at the 3rd rising edge after it goes high.
REQ-008 Timer: 8-bit down counter TMR_COUNT.
- When TMR_CTRL[0]=1: if TMR_COUNT=0, load TMR_RELOAD and set PENDING[4]; otherwise decrement by 1.
- The period SHALL be TMR_RELOAD+1 cycles; TMR_RELOAD=0 SHALL set PENDING[4] every cycle.
REQ-009 When TMR_CTRL[0]=0, TMR_COUNT SHALL hold its value.
REQ-010 A write to TMR_RELOAD SHALL also load TMR_COUNT with out_port on the same edge; this SHALL override decrement and wrap in that cycle, and PENDING[4] SHALL NOT be set by that load.
REQ-011 Simultaneous set and INT_ACK clear of the same PENDING bit in one cycle: set SHALL win.
REQ-012 interrupt SHALL be a registered signal equal to |(PENDING & INT_MASK), asserted one cycle after the pending bit and mask are both set.
REQ-013 interrupt SHALL remain high until every masked pending bit is cleared or masked off, and SHALL deassert one cycle after that.
REQ-014 Writing INT_MASK SHALL NOT alter PENDING; an event arriving while masked SHALL stay pending and raise interrupt once unmasked.

Reset
REQ-015 While rst=0, the block SHALL immediately and asynchronously clear:
- LEDS, SEG, INT_MASK, PENDING, TMR_RELOAD, TMR_CTRL, TMR_COUNT: 0x00
- both synchronizer stages and the edge-detect history: 0
- interrupt: 0
REQ-016 A button already high at reset release SHALL NOT be detected as an edge until it goes low and then high again.
REQ-017 Reset asserted mid-count or with an interrupt pending SHALL abort all activity, with no interrupt on release.
REQ-018 in_port SHALL still follow REQ-005 during reset; the synchronized sources SHALL read 0.

Verification
REQ-019 Bench SHALL cover the following scenarios:
- LED write: io_strb=1, port_id=0x40, out_port=0xA5 -> leds=0xA5 the next cycle; the same strobe with port_id=0x50 -> leds unchanged.
- Button interrupt: INT_MASK=0x01, button[0] rises -> PENDING=0x01 on the 3rd edge, interrupt=1 one cycle later; write 0x43/0x01 -> interrupt=0 one cycle after PENDING clears.
- Timer: TMR_RELOAD=0x03, TMR_CTRL=0x01 -> PENDING[4] sets every 4 cycles; read 0x23 shows the sequence 3,2,1,0,3.
- Ack race: PENDING[4] set-condition and INT_ACK 0x10 in the same cycle -> PENDING[4]=1.
- Masked pending: INT_MASK=0, button[2] rises -> PENDING=0x04, interrupt=0; write INT_MASK=0x04 -> interrupt=1 one cycle after the mask write.
- Async reset: rst=0 mid-count with interrupt=1 -> all outputs 0 without a clock edge; button held high across release -> no PENDING.
